// File: rtl/exmem_pipe_stage.sv
// EX->MEM pipeline register with STAGES chained slots, stall/flush control,
// forwarding-match and load-use hazard outputs. Optional macro: EXMEM_PERF_CNT_EN.
module exmem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_ALU,
    input  logic [DATA_W-1:0] aluResult_ALU,
    input  logic [DATA_W-1:0] op2_ALU,
    input  logic [REG_W-1:0]  rd_ALU,
    input  logic              isWb_ALU,
    input  logic              isLd_ALU,
    input  logic              isSt_ALU,
    input  logic [REG_W-1:0]  rs1_EX,
    input  logic [REG_W-1:0]  rs2_EX,
    output logic              valid_DM,
    output logic [DATA_W-1:0] aluResult_DM,
    output logic [DATA_W-1:0] op2_DM,
    output logic [REG_W-1:0]  rd_DM,
    output logic              isWb_DM,
    output logic              isLd_DM,
    output logic              isSt_DM,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
`ifdef EXMEM_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              ld_use_hazard
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("exmem_pipe_stage: STAGES must be in the range 1..4");
        end
    endgenerate

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0][DATA_W-1:0] r_alu;
    logic [STAGES-1:0][DATA_W-1:0] r_op2;
    logic [STAGES-1:0][REG_W-1:0]  r_rd;
    logic [STAGES-1:0]             r_wb;
    logic [STAGES-1:0]             r_ld;
    logic [STAGES-1:0]             r_st;

    logic w_wb_live;
    logic w_rd_nonzero;

    // Stage shift register: reset clears, flush kills valids only, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_alu   <= '0;
            r_op2   <= '0;
            r_rd    <= '0;
            r_wb    <= '0;
            r_ld    <= '0;
            r_st    <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (!stall) begin
            r_valid[0] <= valid_ALU;
            r_alu[0]   <= aluResult_ALU;
            r_op2[0]   <= op2_ALU;
            r_rd[0]    <= rd_ALU;
            r_wb[0]    <= isWb_ALU;
            r_ld[0]    <= isLd_ALU;
            r_st[0]    <= isSt_ALU;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_alu[k]   <= r_alu[k-1];
                r_op2[k]   <= r_op2[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_wb[k]    <= r_wb[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_st[k]    <= r_st[k-1];
            end
        end
    end

    // Control bits are qualified by valid; payload is presented as stored.
    always_comb begin
        valid_DM     = r_valid[LAST];
        aluResult_DM = r_alu[LAST];
        op2_DM       = r_op2[LAST];
        rd_DM        = r_rd[LAST];
        isWb_DM      = r_wb[LAST] & r_valid[LAST];
        isLd_DM      = r_ld[LAST] & r_valid[LAST];
        isSt_DM      = r_st[LAST] & r_valid[LAST];
    end

    // Forwarding match against the last stage; x0 is hardwired zero so never forwards.
    always_comb begin
        w_rd_nonzero  = (r_rd[LAST] != {REG_W{1'b0}});
        w_wb_live     = r_valid[LAST] & r_wb[LAST] & w_rd_nonzero;
        fwd1_hit      = w_wb_live & (r_rd[LAST] == rs1_EX);
        fwd2_hit      = w_wb_live & (r_rd[LAST] == rs2_EX);
        ld_use_hazard = (fwd1_hit | fwd2_hit) & r_ld[LAST] & r_valid[LAST];
    end

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters; a stall that coincides with flush counts as flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (stall && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench for exmem_pipe_stage: a STAGES=1 and a STAGES=3 instance share
// all inputs; expected values are hand-computed constants and small tables.
module tb_exmem_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_ALU, isWb_ALU, isLd_ALU, isSt_ALU;
    logic [31:0] aluResult_ALU, op2_ALU;
    logic [4:0]  rd_ALU, rs1_EX, rs2_EX;

    logic        v1, wb1, ld1, st1, f1a, f1b, luh1;
    logic [31:0] alu1, op21;
    logic [4:0]  rd1;
    logic        v3, wb3, ld3, st3, f3a, f3b, luh3;
    logic [31:0] alu3, op23;
    logic [4:0]  rd3;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exmem_pipe_stage #(.DATA_W(32), .REG_W(5), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_ALU(valid_ALU),
        .aluResult_ALU(aluResult_ALU), .op2_ALU(op2_ALU), .rd_ALU(rd_ALU),
        .isWb_ALU(isWb_ALU), .isLd_ALU(isLd_ALU), .isSt_ALU(isSt_ALU),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .valid_DM(v1), .aluResult_DM(alu1),
        .op2_DM(op21), .rd_DM(rd1), .isWb_DM(wb1), .isLd_DM(ld1), .isSt_DM(st1),
        .fwd1_hit(f1a), .fwd2_hit(f1b),
`ifdef EXMEM_PERF_CNT_EN
        .stall_cnt(sc1), .flush_cnt(fc1),
`endif
        .ld_use_hazard(luh1)
    );

    exmem_pipe_stage #(.DATA_W(32), .REG_W(5), .STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_ALU(valid_ALU),
        .aluResult_ALU(aluResult_ALU), .op2_ALU(op2_ALU), .rd_ALU(rd_ALU),
        .isWb_ALU(isWb_ALU), .isLd_ALU(isLd_ALU), .isSt_ALU(isSt_ALU),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .valid_DM(v3), .aluResult_DM(alu3),
        .op2_DM(op23), .rd_DM(rd3), .isWb_DM(wb3), .isLd_DM(ld3), .isSt_DM(st3),
        .fwd1_hit(f3a), .fwd2_hit(f3b),
`ifdef EXMEM_PERF_CNT_EN
        .stall_cnt(sc3), .flush_cnt(fc3),
`endif
        .ld_use_hazard(luh3)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic wb, input logic ld, input logic st);
        valid_ALU     = v;
        aluResult_ALU = alu;
        op2_ALU       = alu ^ 32'h0F0F_0F0F;
        rd_ALU        = rd;
        isWb_ALU      = wb;
        isLd_ALU      = ld;
        isSt_ALU      = st;
    endtask

    // Stall scenario for the 3-deep pipe: A,B enter, two stalls hold C on the input.
    logic [7:0]  st_stall = 8'b0000_1100;
    logic [7:0]  st_valid = 8'b0001_1111;
    logic [7:0]  st_expv  = 8'b0111_0000;
    logic [31:0] st_in  [8] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0, 32'h0, 32'h0};
    logic [31:0] st_exp [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA, 32'hB, 32'hC, 32'h0};

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rs1_EX = 5'd5; rs2_EX = 5'd5;
        drive(1'b1, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check_val("rst_valid", {63'd0, v1}, 64'd0);
        check_val("rst_alu", {32'd0, alu1}, 64'd0);
        check_val("rst_op2", {32'd0, op21}, 64'd0);
        check_val("rst_rd", {59'd0, rd1}, 64'd0);
        check_val("rst_ctl", {61'd0, wb1, ld1, st1}, 64'd0);
        check_val("rst_fwd", {61'd0, f1a, f1b, luh1}, 64'd0);
        check_val("rst_valid3", {63'd0, v3}, 64'd0);
`ifdef EXMEM_PERF_CNT_EN
        check_val("rst_cnt", {sc1, fc1}, 64'd0);
`endif

        // Flush together with stall: flush wins and the input is not captured.
        rst = 1'b0; flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        check_val("fs_valid", {63'd0, v1}, 64'd0);
        check_val("fs_wb", {63'd0, wb1}, 64'd0);
        check_val("fs_alu_hold", {32'd0, alu1}, 64'd0);
`ifdef EXMEM_PERF_CNT_EN
        check_val("fs_flush_cnt", {32'd0, fc1}, 64'd1);
        check_val("fs_stall_cnt", {32'd0, sc1}, 64'd0);
`endif

        // Single-stage pass-through.
        drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("pt_valid", {63'd0, v1}, 64'd1);
        check_val("pt_alu", {32'd0, alu1}, 64'h1234);
        check_val("pt_op2", {32'd0, op21}, 64'h0F0F_1D3B);
        check_val("pt_rd", {59'd0, rd1}, 64'd5);
        check_val("pt_ctl", {61'd0, wb1, ld1, st1}, 64'b100);

        // Forwarding from a load in the last stage.
        drive(1'b1, 32'h0000_0100, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rs1_EX = 5'd7; rs2_EX = 5'd3;
        #1;
        check_val("fw_hit1", {63'd0, f1a}, 64'd1);
        check_val("fw_hit2", {63'd0, f1b}, 64'd0);
        check_val("fw_ldu", {63'd0, luh1}, 64'd1);
        rs1_EX = 5'd3; rs2_EX = 5'd7;
        #1;
        check_val("fw_swap", {62'd0, f1a, f1b}, 64'b01);

        // Destination x0 never forwards.
        drive(1'b1, 32'h0000_0200, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        rs1_EX = 5'd0; rs2_EX = 5'd0;
        #1;
        check_val("fw_x0", {61'd0, f1a, f1b, luh1}, 64'd0);

        // Bubble: control gated, payload visible, no forwarding.
        drive(1'b0, 32'h0000_0300, 5'd9, 1'b1, 1'b1, 1'b1);
        tick();
        rs1_EX = 5'd9; rs2_EX = 5'd9;
        #1;
        check_val("bub_valid", {63'd0, v1}, 64'd0);
        check_val("bub_ctl", {61'd0, wb1, ld1, st1}, 64'd0);
        check_val("bub_fwd", {61'd0, f1a, f1b, luh1}, 64'd0);
        check_val("bub_rd", {59'd0, rd1}, 64'd9);

        // Empty the deep pipe, then run the stall table.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("st_flushed", {63'd0, v3}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            stall = st_stall[i];
            drive(st_valid[i], st_in[i], st_in[i][4:0], 1'b1, 1'b0, 1'b0);
            tick();
            check_val($sformatf("st_valid_e%0d", i + 1), {63'd0, v3}, {63'd0, st_expv[i]});
            check_val($sformatf("st_wb_e%0d", i + 1), {63'd0, wb3}, {63'd0, st_expv[i]});
            if (st_expv[i]) begin
                check_val($sformatf("st_alu_e%0d", i + 1), {32'd0, alu3}, {32'd0, st_exp[i]});
            end
        end
        stall = 1'b0;
`ifdef EXMEM_PERF_CNT_EN
        check_val("st_stall_cnt", {32'd0, sc3}, 64'd2);
        check_val("st_flush_cnt", {32'd0, fc3}, 64'd2);
`endif

        // Reset mid-stream discards entries; first entry after reset takes 3 edges.
        drive(1'b1, 32'h0000_0D0D, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mr_valid3", {63'd0, v3}, 64'd0);
        check_val("mr_valid1", {63'd0, v1}, 64'd0);
`ifdef EXMEM_PERF_CNT_EN
        check_val("mr_cnt", {sc3, fc3}, 64'd0);
`endif
        drive(1'b1, 32'h0000_F00D, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("mr_e1", {63'd0, v3}, 64'd0);
        tick();
        check_val("mr_e2", {63'd0, v3}, 64'd0);
        tick();
        check_val("mr_e3_valid", {63'd0, v3}, 64'd1);
        check_val("mr_e3_alu", {32'd0, alu3}, 64'hF00D);
        check_val("mr_e3_ctl", {61'd0, wb3, ld3, st3}, 64'b101);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exmem_pipe_stage.md
# exmem_pipe_stage

Parametrised EX→MEM pipeline register for the SimpleRISC pipeline, carrying the ALU result, store operand, destination register and control bits from the ALU stage to data memory. It generalises the fixed 32-bit single-stage latch with these additions:
- configurable data/register widths and register depth;
- a valid bit per stage, with stall (hold) and flush (bubble) control;
- synchronous reset;
- forwarding-match and load-use hazard outputs for the decode/ALU operand muxes.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store operand
- REG_W, 5, register-index width
- STAGES, 1, number of chained register stages (legal 1..4); outputs taken from last stage

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stages this cycle
- flush  in  1  kill all in-flight entries this cycle
- valid_ALU  in  1  ALU-stage entry is a real instruction
- aluResult_ALU  in  DATA_W  ALU result / memory address
- op2_ALU  in  DATA_W  store data
- rd_ALU  in  REG_W  destination register
- isWb_ALU  in  1  instruction writes rd
- isLd_ALU  in  1  instruction is a load
- isSt_ALU  in  1  instruction is a store
- rs1_EX, rs2_EX  in  REG_W  source registers of instruction currently in ALU stage
- valid_DM  out  1  last stage holds a live entry
- aluResult_DM, op2_DM  out  DATA_W  last-stage payload
- rd_DM  out  REG_W  last-stage destination
- isWb_DM, isLd_DM, isSt_DM  out  1  last-stage control, each ANDed with valid_DM
- fwd1_hit, fwd2_hit  out  1  rs1_EX / rs2_EX matches live writeback in last stage
- ld_use_hazard  out  1  a hit whose last-stage entry is a load
- stall_cnt, flush_cnt  out  32  performance counters (only with EXMEM_PERF_CNT_EN)

## Operation
- Each stage holds {valid, aluResult, op2, rd, isWb, isLd, isSt}.
- Stage 0 loads from the *_ALU inputs. Stage k loads from stage k-1.
- Per-cycle priority: rst > flush > stall > advance.
  - rst: all fields of all stages cleared to 0.
  - flush: all valid bits cleared to 0; payload fields don't-care (implementation holds them).
  - stall: no stage changes; inputs ignored, and the upstream stage must hold them.
  - advance: every stage shifts by one; stage 0 captures inputs, including valid_ALU=0 bubbles.
- Control outputs isWb_DM/isLd_DM/isSt_DM are gated by valid_DM. Payload outputs are ungated.
- Forwarding:
  - fwd1_hit = valid_DM & isWb_DM & (rd_DM != 0) & (rd_DM == rs1_EX); fwd2_hit likewise with rs2_EX.
  - Register 0 never produces a hit.
- ld_use_hazard = (fwd1_hit | fwd2_hit) & isLd_DM.
- Forwarding and hazard outputs are purely combinational from the last-stage registers and rs*_EX. They are valid in the same cycle.

## Timing
- Latency from *_ALU to *_DM: STAGES clock edges with no stall. Throughput: one entry per cycle.
- Each stalled cycle adds exactly one cycle of latency to every in-flight entry.
- Reset values: valid_DM=0, aluResult_DM=0, op2_DM=0, rd_DM=0, isWb_DM=isLd_DM=isSt_DM=0, fwd1_hit=fwd2_hit=ld_use_hazard=0, counters=0.
- Flush and stall asserted together: flush wins and all stages are invalidated. The input entry is not captured.
- Flush takes effect at the edge it is sampled. The next cycle shows valid_DM=0.
- Reset mid-stream discards all entries. The first input after reset deasserts reaches *_DM STAGES edges later.
- An out-of-range STAGES fails elaboration via a generate-time error.

## Configuration
- Macro: EXMEM_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with stall=1 and flush=0 and rst=0.
  - flush_cnt increments on each cycle with flush=1 and rst=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, STAGES=1: assert rst with nonzero inputs → all outputs 0 the cycle after the edge.
- Single stage pass-through: valid_ALU=1, aluResult_ALU=32'h0000_1234, rd_ALU=5, isWb_ALU=1 → next cycle aluResult_DM=32'h1234, rd_DM=5, isWb_DM=1, valid_DM=1.
- STAGES=3 stall: push A, B, C on consecutive cycles; stall for 2 cycles after B enters → A appears at *_DM on edge 5 instead of edge 3; order A, B, C preserved, none dropped or duplicated.
- Flush with stall: flush=1 and stall=1 in the same cycle → valid_DM=0 and isWb_DM=0 next cycle; with EXMEM_PERF_CNT_EN, flush_cnt=1 and stall_cnt=0.
- Forwarding: last stage holds rd_DM=7, isWb=1, isLd=1; drive rs1_EX=7, rs2_EX=3 → fwd1_hit=1, fwd2_hit=0, ld_use_hazard=1. Then rd_DM=0 with rs1_EX=0 → fwd1_hit=0.
- Bubble gating: valid_ALU=0 with isWb_ALU=1, rd_ALU=9 → isWb_DM=0 and no forwarding hit for rs1_EX=9.
